// File: rtl/cond_branch_ctrl_pkg.sv
// Shared constants for the conditional branch controller: CMP opcode,
// comparison-register condition indices and FSM state encoding.
package cond_branch_ctrl_pkg;

  // Opcode of the CMP instruction that writes the comparison register.
  localparam logic [5:0] OPC_CMP = 6'h2A;

  localparam int unsigned COND_W   = 4;
  localparam int unsigned NUM_COND = 12;
  localparam int unsigned CREG_W   = 12;

  // Bit positions in comp_reg, also the br_cond encoding.
  localparam logic [COND_W-1:0] COND_GT     = 4'd0;
  localparam logic [COND_W-1:0] COND_LE     = 4'd1;
  localparam logic [COND_W-1:0] COND_GE     = 4'd2;
  localparam logic [COND_W-1:0] COND_LT     = 4'd3;
  localparam logic [COND_W-1:0] COND_GTU    = 4'd4;
  localparam logic [COND_W-1:0] COND_LEU    = 4'd5;
  localparam logic [COND_W-1:0] COND_GEU    = 4'd6;
  localparam logic [COND_W-1:0] COND_LTU    = 4'd7;
  localparam logic [COND_W-1:0] COND_NE     = 4'd8;
  localparam logic [COND_W-1:0] COND_EQ     = 4'd9;
  localparam logic [COND_W-1:0] COND_NEVER  = 4'd10;
  localparam logic [COND_W-1:0] COND_ALWAYS = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  // True when a condition index selects a real comp_reg bit.
  function automatic logic cond_is_valid(input logic [COND_W-1:0] c);
    return c < COND_W'(NUM_COND);
  endfunction

endpackage

// File: rtl/cmp_pend_cnt.sv
// Outstanding-CMP counter: up on accepted issue, down on done, full flag
// registered so cmp_ready is a clean flop output.
module cmp_pend_cnt #(
  parameter int unsigned MAX_PEND = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic cmp_issue,
  input  logic cmp_done,
  output logic cmp_ready,
  output logic pend_zero_nxt_c
);

  localparam int unsigned CNT_W = 3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             inc, dec;

  // Next count: issue only accepted when not full, done ignored at zero.
  always_comb begin
    inc   = cmp_issue & ~full_q;
    dec   = cmp_done & (cnt_q != '0);
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    full_d = (cnt_d >= CNT_W'(MAX_PEND));
  end

  // Counter and full flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign cmp_ready       = ~full_q;
  assign pend_zero_nxt_c = (cnt_d == '0);

endmodule

// File: rtl/cond_branch_ctrl.sv
// Conditional branch controller: waits for outstanding CMPs, resolves the
// branch against comp_reg, redirects fetch and flushes the pipeline.
// Optional feature macro: BRANCH_STATS_EN adds taken/not-taken counters.
module cond_branch_ctrl
  import cond_branch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = 16,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_PEND     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmp_issue,
  output logic              cmp_ready,
  input  logic              cmp_done,
  input  logic [CREG_W-1:0] comp_reg,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [COND_W-1:0] br_cond,
  input  logic [PC_W-1:0]   br_target,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush,
  output logic              stall,
  output logic              cond_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       nt_cnt
`endif
);

  localparam int unsigned FL_W = 3;
  localparam logic [FL_W-1:0] FL_LOAD =
    (FLUSH_CYCLES > 0) ? FL_W'(FLUSH_CYCLES - 1) : FL_W'(0);

  state_e              state_q, state_d;
  logic [COND_W-1:0]   cond_q, cond_d;
  logic [PC_W-1:0]     tgt_q, tgt_d;
  logic [FL_W-1:0]     fl_cnt_q, fl_cnt_d;
  logic                br_ready_q, br_ready_d;
  logic                stall_q, stall_d;
  logic                flush_q, flush_d;

  logic                pend_zero_nxt_c;
  logic [15:0]         creg_ext_c;
  logic                taken_c;
  logic                resolve_c;

  cmp_pend_cnt #(
    .MAX_PEND (MAX_PEND)
  ) u_pend (
    .clk             (clk),
    .reset           (reset),
    .cmp_issue       (cmp_issue),
    .cmp_done        (cmp_done),
    .cmp_ready       (cmp_ready),
    .pend_zero_nxt_c (pend_zero_nxt_c)
  );

  // Branch outcome: comp_reg is looked at only while resolving, so the
  // redirect/error outputs are decoded from it in that cycle.
  always_comb begin
    creg_ext_c = {4'b0000, comp_reg};
    resolve_c  = (state_q == ST_RESOLVE) && !reset;
    taken_c    = cond_is_valid(cond_q) && creg_ext_c[cond_q];
  end

  assign redirect_valid = resolve_c & taken_c;
  assign redirect_pc    = redirect_valid ? tgt_q : '0;
  assign cond_err       = resolve_c & ~cond_is_valid(cond_q);

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    tgt_d    = tgt_q;
    fl_cnt_d = fl_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          cond_d  = br_cond;
          tgt_d   = br_target;
          state_d = pend_zero_nxt_c ? ST_RESOLVE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pend_zero_nxt_c) begin
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (taken_c && (FLUSH_CYCLES > 0)) begin
          state_d  = ST_FLUSH;
          fl_cnt_d = FL_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (fl_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          fl_cnt_d = fl_cnt_q - FL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    br_ready_d = (state_d == ST_IDLE);
    stall_d    = (state_d == ST_WAIT) || (state_d == ST_RESOLVE);
    flush_d    = (state_d == ST_FLUSH);
  end

  // FSM, captured branch and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cond_q     <= '0;
      tgt_q      <= '0;
      fl_cnt_q   <= '0;
      br_ready_q <= 1'b1;
      stall_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cond_q     <= cond_d;
      tgt_q      <= tgt_d;
      fl_cnt_q   <= fl_cnt_d;
      br_ready_q <= br_ready_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign br_ready = br_ready_q;
  assign stall    = stall_q;
  assign flush    = flush_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, nt_cnt_q;

  // Saturating outcome counters, one count per resolved branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
    end else if (state_q == ST_RESOLVE) begin
      if (taken_c) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else begin
        if (nt_cnt_q != 16'hFFFF) nt_cnt_q <= nt_cnt_q + 16'd1;
      end
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign nt_cnt    = nt_cnt_q;
`endif

endmodule

// File: tb/tb_cond_branch_ctrl.sv
// Self-checking bench for cond_branch_ctrl (default parameters).
module tb_cond_branch_ctrl;

  localparam int unsigned PC_W = 16;
  localparam int unsigned FL   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmp_issue, cmp_ready, cmp_done;
  logic [11:0]     comp_reg;
  logic            br_valid, br_ready;
  logic [3:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush, stall, cond_err;
`ifdef BRANCH_STATS_EN
  logic [15:0]     taken_cnt, nt_cnt;
`endif

  always #5 clk = ~clk;

  cond_branch_ctrl #(
    .PC_W         (PC_W),
    .FLUSH_CYCLES (FL),
    .MAX_PEND     (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmp_issue      (cmp_issue),
    .cmp_ready      (cmp_ready),
    .cmp_done       (cmp_done),
    .comp_reg       (comp_reg),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .br_target      (br_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .stall          (stall),
    .cond_err       (cond_err)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt      (taken_cnt),
    .nt_cnt         (nt_cnt)
`endif
  );

  typedef struct {
    logic            rv;
    logic [PC_W-1:0] pc;
    logic            ce;
  } exp_t;

  typedef struct {
    logic [3:0]      cond;
    logic [11:0]     creg;
    logic [PC_W-1:0] tgt;
    logic            rv;
    logic            ce;
  } vec_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (br_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(br_ready), 32'd1);
  endtask

  // Scoreboard: every redirect or cond_err pulse must match a pushed entry.
  always @(negedge clk) begin
    if (redirect_valid === 1'b1 || cond_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL spurious_out: rv=%0b pc=0x%0h ce=%0b with nothing expected at %0t",
                 redirect_valid, redirect_pc, cond_err, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_redirect_valid", 32'(redirect_valid), 32'(e.rv));
        chk("sb_redirect_pc", 32'(redirect_pc), 32'(e.pc));
        chk("sb_cond_err", 32'(cond_err), 32'(e.ce));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];

  initial begin
    vecs[0] = '{cond: 4'd11, creg: 12'h800, tgt: 16'h0040, rv: 1'b1, ce: 1'b0};
    vecs[1] = '{cond: 4'd9,  creg: 12'h800, tgt: 16'h0050, rv: 1'b0, ce: 1'b0};
    vecs[2] = '{cond: 4'd9,  creg: 12'hA00, tgt: 16'h1234, rv: 1'b1, ce: 1'b0};
    vecs[3] = '{cond: 4'd0,  creg: 12'h001, tgt: 16'hFFFE, rv: 1'b1, ce: 1'b0};
    vecs[4] = '{cond: 4'd3,  creg: 12'hFF7, tgt: 16'h0100, rv: 1'b0, ce: 1'b0};
    vecs[5] = '{cond: 4'd10, creg: 12'h400, tgt: 16'h0002, rv: 1'b1, ce: 1'b0};
    vecs[6] = '{cond: 4'd12, creg: 12'hFFF, tgt: 16'h0AAA, rv: 1'b0, ce: 1'b1};
    vecs[7] = '{cond: 4'd13, creg: 12'hFFF, tgt: 16'h0BBB, rv: 1'b0, ce: 1'b1};
    vecs[8] = '{cond: 4'd7,  creg: 12'h080, tgt: 16'hABCD, rv: 1'b1, ce: 1'b0};

    reset = 1'b1; cmp_issue = 1'b0; cmp_done = 1'b0; comp_reg = 12'h800;
    br_valid = 1'b0; br_cond = '0; br_target = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    chk("rst_cmp_ready", 32'(cmp_ready), 32'd1);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cond_err", 32'(cond_err), 32'd0);

    // Table: branch with no pending CMP; comp_reg holds a decoy in the
    // accept cycle so only the resolve-cycle value may decide.
    foreach (vecs[i]) begin
      chk("vec_idle_ready", 32'(br_ready), 32'd1);
      br_valid = 1'b1; br_cond = vecs[i].cond; br_target = vecs[i].tgt;
      comp_reg = ~vecs[i].creg;
      if (vecs[i].rv || vecs[i].ce)
        exp_q.push_back('{rv: vecs[i].rv, pc: vecs[i].rv ? vecs[i].tgt : 16'h0, ce: vecs[i].ce});
      tick();
      br_valid = 1'b0; comp_reg = vecs[i].creg;
      #1;
      chk("vec_resolve_stall", 32'(stall), 32'd1);
      chk("vec_resolve_br_ready", 32'(br_ready), 32'd0);
      chk("vec_resolve_flush", 32'(flush), 32'd0);
      if (!(vecs[i].rv || vecs[i].ce)) begin
        chk("vec_nt_redirect", 32'(redirect_valid), 32'd0);
        chk("vec_nt_cond_err", 32'(cond_err), 32'd0);
      end
      if (vecs[i].rv) begin
        for (int k = 0; k < int'(FL); k++) begin
          tick();
          chk("vec_flush_hi", 32'(flush), 32'd1);
          chk("vec_flush_br_ready", 32'(br_ready), 32'd0);
          chk("vec_flush_stall", 32'(stall), 32'd0);
        end
      end
      tick();
      chk("vec_done_flush", 32'(flush), 32'd0);
      chk("vec_done_br_ready", 32'(br_ready), 32'd1);
    end

    // Branch behind a pending CMP: stall T+2..T+4, redirect at T+4.
    comp_reg = 12'h000;
    cmp_issue = 1'b1;
    tick();
    cmp_issue = 1'b0;
    br_valid = 1'b1; br_cond = 4'd9; br_target = 16'h0300;
    #1;
    chk("wait_accept_ready", 32'(br_ready), 32'd1);
    tick();
    br_valid = 1'b0;
    #1;
    chk("wait_t2_stall", 32'(stall), 32'd1);
    chk("wait_t2_br_ready", 32'(br_ready), 32'd0);
    chk("wait_t2_redirect", 32'(redirect_valid), 32'd0);
    tick();
    cmp_done = 1'b1;
    #1;
    chk("wait_t3_stall", 32'(stall), 32'd1);
    chk("wait_t3_redirect", 32'(redirect_valid), 32'd0);
    tick();
    cmp_done = 1'b0; comp_reg = 12'h200;
    exp_q.push_back('{rv: 1'b1, pc: 16'h0300, ce: 1'b0});
    #1;
    chk("wait_t4_stall", 32'(stall), 32'd1);
    tick();
    chk("wait_t5_flush", 32'(flush), 32'd1);
    chk("wait_t5_stall", 32'(stall), 32'd0);
    wait_ready(10);

    // Pending counter limits, simultaneous issue/done, underflow guard.
    for (int k = 0; k < 3; k++) begin
      chk("pend_ready_before_issue", 32'(cmp_ready), 32'd1);
      cmp_issue = 1'b1;
      tick();
    end
    cmp_issue = 1'b0;
    #1;
    chk("pend_full", 32'(cmp_ready), 32'd0);
    cmp_issue = 1'b1;
    tick();
    cmp_issue = 1'b0;
    #1;
    chk("pend_fourth_ignored", 32'(cmp_ready), 32'd0);
    cmp_done = 1'b1;
    tick();
    cmp_done = 1'b0;
    #1;
    chk("pend_after_done", 32'(cmp_ready), 32'd1);
    cmp_issue = 1'b1; cmp_done = 1'b1;
    tick();
    cmp_issue = 1'b0; cmp_done = 1'b0;
    #1;
    chk("pend_simul_ready", 32'(cmp_ready), 32'd1);
    cmp_issue = 1'b1;
    tick();
    cmp_issue = 1'b0;
    #1;
    chk("pend_refull", 32'(cmp_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cmp_done = 1'b1;
      tick();
      cmp_done = 1'b0;
      #1;
      chk("pend_drain_ready", 32'(cmp_ready), 32'd1);
    end
    cmp_done = 1'b1;
    tick();
    cmp_done = 1'b0;
    #1;
    chk("pend_underflow_ready", 32'(cmp_ready), 32'd1);
    // Count must be back at zero: branch resolves straight away.
    comp_reg = 12'h800;
    br_valid = 1'b1; br_cond = 4'd11; br_target = 16'h0777;
    tick();
    br_valid = 1'b0;
    exp_q.push_back('{rv: 1'b1, pc: 16'h0777, ce: 1'b0});
    #1;
    chk("pend_zero_resolve_stall", 32'(stall), 32'd1);
    // Reset during FLUSH drops flush and returns to IDLE.
    tick();
    chk("rstfl_flush_hi", 32'(flush), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rstfl_flush_lo", 32'(flush), 32'd0);
    chk("rstfl_br_ready", 32'(br_ready), 32'd1);
    chk("rstfl_stall", 32'(stall), 32'd0);

    // Reset during RESOLVE of a taken branch: no redirect at all.
    br_valid = 1'b1; br_cond = 4'd11; br_target = 16'h0999;
    tick();
    br_valid = 1'b0; reset = 1'b1;
    #1;
    chk("rstres_redirect", 32'(redirect_valid), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rstres_br_ready", 32'(br_ready), 32'd1);
    chk("rstres_flush", 32'(flush), 32'd0);
    tick();
    chk("rstres_redirect_after", 32'(redirect_valid), 32'd0);
    tick();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
